regfile_dump: RTL
=================

# regfile_dump

Register file for the single-cycle datapath: DEPTH x WIDTH storage with one synchronous write port, two combinational read ports, and a serial readout engine. On request, the readout engine streams every register out over a valid/ready handshake. The datapath writes the array each cycle; the dump engine reads it out for the debug/trace path without stalling the datapath.

## Interface
- DEPTH, 8, number of registers
- WIDTH, 8, register width in bits
- ADDR_W, 3, address width; DEPTH == 2**ADDR_W
- clk  input  1  clock; all state updates on posedge
- reset  input  1  reset, synchronous, active-high; clock clk
- we  input  1  write enable
- waddr  input  ADDR_W  write address
- wdata  input  WIDTH  write data
- raddr_a  input  ADDR_W  read port A address
- rdata_a  output  WIDTH  read port A data, combinational
- raddr_b  input  ADDR_W  read port B address
- rdata_b  output  WIDTH  read port B data, combinational
- dump_start  input  1  request a full dump; sampled only in IDLE
- dump_busy  output  1  high in SEND and DONE
- dump_valid  output  1  dump beat available
- dump_ready  input  1  sink accepts beat
- dump_addr  output  ADDR_W  index of the current beat
- dump_data  output  WIDTH  registered snapshot of the register at dump_addr
- dump_done  output  1  one-cycle pulse after the last beat is accepted

## Operation
- Reset: all registers are 0. FSM enters IDLE. dump_busy, dump_valid and dump_done are 0. dump_addr and dump_data are 0.
- Write: if we is high at a posedge, mem[waddr] <= wdata. All addresses, including 0, are writable.
- Read ports: rdata_x = mem[raddr_x]. Bypass behaviour is covered in Configuration.
- FSM states:
  - IDLE: if dump_start is high, go to SEND. Set ptr = 0 and load dump_data <= mem[0].
  - SEND: dump_valid = 1 and dump_addr = ptr.
    - A beat is accepted when dump_valid && dump_ready.
    - On acceptance with ptr == DEPTH-1, go to DONE.
    - On acceptance otherwise, ptr <= ptr+1 and dump_data <= mem[ptr+1].
    - With no acceptance, dump_data and dump_addr hold.
  - DONE: dump_done = 1 for exactly one cycle, then go to IDLE.
- Snapshot rule: each dump_data load reads the stored value before any same-cycle write, regardless of macro. A later write to an address that is already snapshotted does not change the held dump_data.
- dump_start is ignored in SEND and DONE. A start in the DONE cycle is dropped.
- Reset mid-dump: on the next posedge, the FSM returns to IDLE, outputs take their reset values and the array clears. The in-flight beat is lost.
- Width rules: ptr is ADDR_W bits. The last-beat test is an explicit compare with DEPTH-1; ptr never wraps past DEPTH-1.

## Timing
- Write latency: data written at posedge T is visible on rdata_x from T onward, i.e. in the cycle after we was asserted.
- dump_start high in cycle N gives dump_valid high in cycle N+1 with dump_addr = 0.
- Throughput: 1 beat per cycle while dump_ready is held high.
- Full dump with dump_ready held high: beats in cycles N+1 to N+DEPTH, dump_done in cycle N+DEPTH+1, IDLE in cycle N+DEPTH+2.
- Backpressure: the number of cycles with dump_ready low adds one-for-one to the total dump time.
- The write port and read ports are fully independent of the dump engine; there are no stalls.

## Configuration
- REGFILE_BYPASS_EN defined: when we is high and raddr_x == waddr, rdata_x = wdata combinationally in the same cycle (write-first).
- REGFILE_BYPASS_EN undefined: rdata_x always shows stored contents, so it shows the old value during a same-address write.
- The macro does not affect the dump snapshot rule.

## Test plan
- Reset then read: assert reset for 2 cycles, then sweep raddr_a and raddr_b over 0..7 -> all reads are 0x00; dump_busy, dump_valid and dump_done are 0.
- Write/readback: write 0x11*i to addr i for i = 0..7, then read -> rdata_a[3] = 0x33 and rdata_b[7] = 0x77. A same-cycle read of addr 5 while writing 0xA5 returns 0xA5 with REGFILE_BYPASS_EN and 0x55 without it.
- Full dump, ready high: preload as above, pulse dump_start in cycle N -> beats (addr i, data 0x11*i) in cycles N+1..N+8, dump_done high only in N+9, dump_busy low in N+10.
- Backpressure: hold dump_ready low for 3 cycles during beat 2 -> dump_addr = 2 and dump_data = 0x22 stay stable; dump_done is 3 cycles later than in the ready-high case.
- Snapshot/concurrent write: during the dump, write 0xFF to addr 4 in the cycle beat 3 is accepted, so the beat-4 snapshot is loaded in that cycle -> beat 4 carries 0x44 and a later read of addr 4 returns 0xFF. A write of 0xEE to addr 6 in the same period -> beat 6 carries 0xEE. Pulsing dump_start mid-dump has no effect.
- Reset mid-dump: assert reset while dump_addr = 5 -> next cycle dump_valid = 0, FSM is IDLE, no dump_done pulse, all reads are 0x00. A fresh dump then streams eight 0x00 beats.

Source files
------------

// File: rtl/regfile_dump.sv
// DEPTH x WIDTH register file with two combinational read ports and a serial
// dump engine; define REGFILE_BYPASS_EN for write-first read-port bypass.
module regfile_dump #(
  parameter int DEPTH  = 8,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [WIDTH-1:0]  rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_b,
  input  logic              dump_start,
  output logic              dump_busy,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [WIDTH-1:0]  dump_data,
  output logic              dump_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [WIDTH-1:0]  mem [DEPTH];
  state_t            state;
  logic [ADDR_W-1:0] ptr;

  // NOTE: the array is cleared by reset, so it must be built from flops rather
  // than a RAM macro; RAM blocks cannot be reset in one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    rdata_a = (we && raddr_a == waddr) ? wdata : mem[raddr_a];
    rdata_b = (we && raddr_b == waddr) ? wdata : mem[raddr_b];
  end
`else
  always_comb begin
    rdata_a = mem[raddr_a];
    rdata_b = mem[raddr_b];
  end
`endif

  assign dump_addr = ptr;

  // NOTE: non-blocking updates mean the snapshot loads below read mem as it
  // stood before this edge, so a same-cycle write never leaks into dump_data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= '0;
      dump_data  <= '0;
      dump_valid <= 1'b0;
      dump_busy  <= 1'b0;
      dump_done  <= 1'b0;
    end else begin
      dump_done <= 1'b0;
      case (state)
        IDLE: begin
          if (dump_start) begin
            state      <= SEND;
            ptr        <= '0;
            dump_data  <= mem[0];
            dump_valid <= 1'b1;
            dump_busy  <= 1'b1;
          end
        end
        SEND: begin
          if (dump_ready) begin
            if (ptr == LAST) begin
              state      <= DONE;
              dump_valid <= 1'b0;
              dump_done  <= 1'b1;
            end else begin
              ptr       <= ptr + 1'b1;
              dump_data <= mem[ptr + 1'b1];
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          dump_busy <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          dump_valid <= 1'b0;
          dump_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
